// File: rtl/frame_readout_arbiter.sv
// Frame-granular round-robin merge of N_CH channel word streams into one
// registered readout stream; a granted frame is never interleaved.
module frame_readout_arbiter #(
  parameter int N_CH            = 4,
  parameter int DOUT_WIDTH      = 64,
  parameter int CH_ID_WIDTH     = 2,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [N_CH-1:0]              CH_EN,
  input  logic [N_CH*DOUT_WIDTH-1:0]   CH_DIN,
  input  logic [N_CH-1:0]              CH_VALID,
  input  logic [N_CH-1:0]              CH_LAST,
  output logic [N_CH-1:0]              CH_READY,
  input  logic                         iREADY,
  output logic [DOUT_WIDTH-1:0]        DOUT,
  output logic                         oVALID,
  output logic                         oLAST,
  output logic [CH_ID_WIDTH-1:0]       oCH_ID,
  output logic [FRAME_CNT_WIDTH-1:0]   FRAME_CNT
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                  state;
  logic [CH_ID_WIDTH-1:0]  grant;
  logic [CH_ID_WIDTH-1:0]  last_grant;
  logic [CH_ID_WIDTH-1:0]  next_grant;
  logic                    found;
  logic [N_CH-1:0]         req;
  logic                    out_ready;
  logic                    accept;
  logic [DOUT_WIDTH-1:0]   ch_word [N_CH];

  assign req       = CH_VALID & CH_EN;
  assign out_ready = ~oVALID | iREADY;
  assign accept    = (state == XFER) && CH_VALID[grant] && out_ready;

  // Ready depends only on state, grant, oVALID and iREADY, never on CH_VALID.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign ch_word[gi]  = CH_DIN[gi*DOUT_WIDTH +: DOUT_WIDTH];
    assign CH_READY[gi] = (state == XFER) && (grant == CH_ID_WIDTH'(gi)) && out_ready;
  end

  // Round-robin search starting just after the last channel that finished a frame.
  always_comb begin
    next_grant = '0;
    found      = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      if (!found && req[(int'(last_grant) + i) % N_CH]) begin
        next_grant = CH_ID_WIDTH'((int'(last_grant) + i) % N_CH);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= CH_ID_WIDTH'(N_CH - 1);
      DOUT       <= '0;
      oVALID     <= 1'b0;
      oLAST      <= 1'b0;
      oCH_ID     <= '0;
      FRAME_CNT  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= next_grant;
            state <= XFER;
          end
        end
        XFER: begin
          if (accept && CH_LAST[grant]) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        DOUT   <= ch_word[grant];
        oLAST  <= CH_LAST[grant];
        oCH_ID <= grant;
        oVALID <= 1'b1;
      end else if (iREADY) begin
        oVALID <= 1'b0;
      end

      if (oVALID && iREADY && oLAST) begin
        FRAME_CNT <= FRAME_CNT + FRAME_CNT_WIDTH'(1);
      end
    end
  end

endmodule
